// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the memory request sequencer
package mem_pkg;

    localparam int MEM_AWIDTH = 16;
    localparam int MEM_DWIDTH = 32;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_RESP
    } mem_state_e;

    typedef struct packed {
        logic                  rw;
        logic [MEM_AWIDTH-1:0] addr;
        logic [MEM_DWIDTH-1:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/mem_req_fifo.sv
// rtl/mem_req_fifo.sv - DEPTH-entry synchronous command FIFO with occupancy count
module mem_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = PW + 1;
    localparam logic [PW:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW:0]      count_q, count_d;
    logic             do_push, do_pop;

    // Full is taken from the registered count, so a pop frees its slot one cycle later.
    assign full     = (count_q == FULL_COUNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mem_req_queue.sv
// rtl/mem_req_queue.sv - queued CPU requests replayed one at a time to the memory controller; MEMQ_TIMEOUT_EN adds wait-state timeout
module mem_req_queue
    import mem_pkg::*;
#(
    parameter int DWIDTH = MEM_DWIDTH,
    parameter int AWIDTH = MEM_AWIDTH,
    parameter int DEPTH  = 4
`ifdef MEMQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 15
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [DWIDTH-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              Valid,
    output logic              RW,
    output logic [AWIDTH-1:0] Addr_in,
    output logic [DWIDTH-1:0] Data_out,
    output logic              Data_oe,
    input  logic [DWIDTH-1:0] Data_rd,
    input  logic              Ready
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    mem_state_e        state_q, state_d;
    mem_cmd_t          txn_q, txn_d;
    mem_cmd_t          fifo_wr, fifo_rd;
    logic [DWIDTH-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              active;
    logic              tmo_hit;

    assign fifo_wr   = '{rw: cmd_rw, addr: cmd_addr, wdata: cmd_wdata};
    assign cmd_ready = ~fifo_full;
    assign fifo_push = cmd_valid & ~fifo_full;
    assign fifo_pop  = (state_q == ST_IDLE) & ~fifo_empty;

    mem_req_fifo #(
        .WIDTH ($bits(mem_cmd_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (fifo_wr),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

`ifdef MEMQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

    logic [TW-1:0] tmo_q, tmo_d, tmo_inc;

    assign tmo_inc = tmo_q + TW'(1);
    assign tmo_hit = (tmo_inc == TMO_LIMIT);

    // Restarts from zero on every entry into a wait state, including WAIT_LO -> WAIT_HI.
    always_comb begin
        tmo_d = '0;
        if ((state_q == ST_WAIT_LO || state_q == ST_WAIT_HI) && state_d == state_q) begin
            tmo_d = tmo_inc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        txn_d   = txn_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (fifo_count != '0) begin
                    txn_d   = fifo_rd;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT_LO;
            ST_WAIT_LO: begin
                if (!Ready) begin
                    state_d = ST_WAIT_HI;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_WAIT_HI: begin
                if (Ready) begin
                    if (txn_q.rw == RW_READ) begin
                        rdata_d = Data_rd;
                    end
                    state_d = ST_RESP;
                end else if (tmo_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            txn_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            txn_q   <= txn_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Bus outputs decode straight from registers so an async reset clears them at once.
    assign active    = (state_q == ST_ISSUE) || (state_q == ST_WAIT_LO) || (state_q == ST_WAIT_HI);
    assign Valid     = (state_q == ST_ISSUE);
    assign RW        = active ? txn_q.rw : RW_READ;
    assign Addr_in   = txn_q.addr;
    assign Data_out  = txn_q.wdata;
    assign Data_oe   = active && (txn_q.rw == RW_WRITE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_req_queue.sv
// tb/tb_mem_req_queue.sv - randomized and directed bench for mem_req_queue against a transaction schedule model
module tb_mem_req_queue;
    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int TMO   = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_rw;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_err;
    logic [DW-1:0] rsp_rdata;
    logic          Valid, RW, Data_oe, Ready;
    logic [AW-1:0] Addr_in;
    logic [DW-1:0] Data_out, Data_rd;

    always #5 clk = ~clk;

    mem_req_queue dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rw    (cmd_rw),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .Valid     (Valid),
        .RW        (RW),
        .Addr_in   (Addr_in),
        .Data_out  (Data_out),
        .Data_oe   (Data_oe),
        .Data_rd   (Data_rd),
        .Ready     (Ready)
    );

    // Each command's issue and response cycle follows from its push cycle and the previous response.
    typedef struct {
        bit            rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_rdata;
        bit            exp_err;
        int            push_t;
        int            issue_t;
        int            resp_t;
    } tx_t;

    tx_t           txq[$];
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] ctl_mem [int];
    int            t = 0;
    int            last_resp = -100;
    int            checks = 0;
    int            failures = 0;
    bit            stuck = 1'b0;
    bit            hang_cmd = 1'b0;
    bit            ctl_phase = 1'b0;
    bit            last_pushed;
    int            hang_idx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, expv, t);
        end
    endtask

    function automatic int occ(input int tt);
        int n = 0;
        foreach (txq[k]) begin
            if (txq[k].push_t <= tt) n++;
            if (txq[k].issue_t <= tt) n--;
        end
        return n;
    endfunction

    task automatic add_tx();
        tx_t x;
        x.rw        = cmd_rw;
        x.addr      = cmd_addr;
        x.wdata     = cmd_wdata;
        x.push_t    = t;
        x.issue_t   = (t + 1 > last_resp + 2) ? t + 1 : last_resp + 2;
        x.exp_err   = hang_cmd;
        x.resp_t    = x.issue_t + (hang_cmd ? TMO + 1 : 3);
        x.exp_rdata = '0;
        if (!hang_cmd) begin
            if (cmd_rw) begin
                if (ref_mem.exists(int'(cmd_addr))) x.exp_rdata = ref_mem[int'(cmd_addr)];
            end else begin
                ref_mem[int'(cmd_addr)] = cmd_wdata;
            end
        end
        last_resp = x.resp_t;
        txq.push_back(x);
    endtask

    task automatic check_outputs();
        int a = -1;
        int r = -1;
        bit exp_valid = 1'b0;
        foreach (txq[k]) begin
            if (txq[k].issue_t <= t && t < txq[k].resp_t) a = k;
            if (txq[k].resp_t == t) r = k;
        end
        if (a >= 0) exp_valid = (txq[a].issue_t == t);
        chk("cmd_ready", 64'(cmd_ready), 64'(occ(t) < DEPTH));
        chk("Valid", 64'(Valid), 64'(exp_valid));
        if (a >= 0) begin
            chk("RW", 64'(RW), 64'(txq[a].rw));
            chk("Addr_in", 64'(Addr_in), 64'(txq[a].addr));
            chk("Data_oe", 64'(Data_oe), 64'(!txq[a].rw));
            if (!txq[a].rw) chk("Data_out", 64'(Data_out), 64'(txq[a].wdata));
        end else begin
            chk("RW_idle", 64'(RW), 64'd1);
            chk("Data_oe_idle", 64'(Data_oe), 64'd0);
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(r >= 0));
        if (r >= 0) begin
            chk("rsp_rdata", 64'(rsp_rdata), 64'(txq[r].exp_rdata));
            chk("rsp_err", 64'(rsp_err), 64'(txq[r].exp_err));
        end
    endtask

    // One clock: register the push, let the controller model react just after the edge, then check.
    task automatic tick();
        bit            will_push, vb, vrw;
        logic [AW-1:0] va;
        logic [DW-1:0] vd;
        will_push = cmd_valid && (occ(t) < DEPTH);
        vb  = Valid;
        vrw = RW;
        va  = Addr_in;
        vd  = Data_out;
        @(posedge clk);
        t++;
        last_pushed = will_push;
        if (will_push) add_tx();
        #1;
        if (ctl_phase) begin
            Ready     = 1'b1;
            ctl_phase = 1'b0;
        end else if (vb && !stuck) begin
            if (vrw) Data_rd = ctl_mem.exists(int'(va)) ? ctl_mem[int'(va)] : '0;
            else ctl_mem[int'(va)] = vd;
            Ready     = 1'b0;
            ctl_phase = 1'b1;
        end
        check_outputs();
    endtask

    task automatic drive(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cmd_valid = 1'b1;
        cmd_rw    = rw;
        cmd_addr  = a;
        cmd_wdata = d;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_Valid"}, 64'(Valid), 64'd0);
        chk({tag, "_RW"}, 64'(RW), 64'd1);
        chk({tag, "_Data_oe"}, 64'(Data_oe), 64'd0);
        chk({tag, "_Addr_in"}, 64'(Addr_in), 64'd0);
        chk({tag, "_Data_out"}, 64'(Data_out), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
        chk({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    endtask

    task automatic hold_reset();
        cmd_valid = 1'b0;
        txq.delete();
        last_resp = -100;
        Ready     = 1'b1;
        ctl_phase = 1'b0;
        repeat (2) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", t);
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_rw    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        Ready     = 1'b1;
        Data_rd   = '0;

        #1 reset = 1'b1;
        #2 check_reset_values("por");
        hold_reset();

        // Single write then read-back of the same address.
        drive(1'b0, 16'h0012, 32'hDEADBEEF);
        tick();
        cmd_valid = 1'b0;
        repeat (8) tick();
        drive(1'b1, 16'h0012, 32'h0);
        tick();
        cmd_valid = 1'b0;
        repeat (8) tick();

        // Five back-to-back commands against a four-entry queue.
        for (int i = 0; i < 5; i++) begin
            drive(i[0], 16'h0012 + 16'(i), 32'hA5A5_0000 + 32'(i));
            for (int g = 0; g < 40; g++) begin
                tick();
                if (last_pushed) break;
            end
        end
        cmd_valid = 1'b0;
        repeat (35) tick();

        // Three idle cycles between responses and the next command.
        drive(1'b0, 16'h0015, 32'h0BAD_F00D);
        tick();
        cmd_valid = 1'b0;
        repeat (7) tick();
        drive(1'b1, 16'h0015, 32'h0);
        tick();
        cmd_valid = 1'b0;
        repeat (8) tick();

`ifdef MEMQ_TIMEOUT_EN
        stuck    = 1'b1;
        hang_cmd = 1'b1;
        drive(1'b1, 16'h0014, 32'h0);
        tick();
        hang_idx = txq.size() - 1;
        hang_cmd = 1'b0;
        drive(1'b0, 16'h0014, 32'h1234_5678);
        tick();
        cmd_valid = 1'b0;
        for (int g = 0; g < 40 && t < txq[hang_idx].resp_t; g++) tick();
        stuck = 1'b0;
        repeat (20) tick();
`endif

        repeat (300) begin
            cmd_valid = ($urandom_range(0, 2) != 0);
            cmd_rw    = 1'($urandom_range(0, 1));
            cmd_addr  = 16'h0010 + 16'($urandom_range(0, 7));
            cmd_wdata = $urandom;
            tick();
        end
        cmd_valid = 1'b0;
        repeat (40) tick();

        // Reset while the first command sits in WAIT_LO with two more queued.
        drive(1'b0, 16'h0030, 32'hCAFE_0030);
        tick();
        drive(1'b1, 16'h0031, 32'h0);
        tick();
        drive(1'b1, 16'h0032, 32'h0);
        tick();
        chk("pre_reset_Data_oe", 64'(Data_oe), 64'd1);
        #2 reset = 1'b1;
        #1 chk("mid_reset_Valid", 64'(Valid), 64'd0);
        chk("mid_reset_RW", 64'(RW), 64'd1);
        chk("mid_reset_Data_oe", 64'(Data_oe), 64'd0);
        chk("mid_reset_rsp_valid", 64'(rsp_valid), 64'd0);
        hold_reset();
        repeat (10) tick();
        drive(1'b1, 16'h0030, 32'h0);
        tick();
        cmd_valid = 1'b0;
        repeat (8) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
